lxcache_req_arbiter: RTL and testbench

- Round-robin arbiter that shares the single processor-side request port of the Lx cache controller among `NUM_PORTS` upper-level (L1) requesters.
- Grants one requester at a time, holds the request on the controller until the controller completes it, then routes the response back to that requester.
- Broadcasts controller-initiated `REQ_FLUSH` callbacks to all requesters and restricts arbitration to flush traffic until the flush transaction closes.
- Sits between the L1 bus interfaces and `Lxcache_controller` (`address`/`data_in`/`msg_in`/`pending_requests`/`msg_out`/`out_address`/`data_out`).

---
 rtl/lxcache_arb_pkg.sv | 33 +++
 rtl/lxcache_req_arbiter_picker.sv | 30 +++
 rtl/lxcache_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_lxcache_req_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lxcache_arb_pkg.sv
// Shared types and message encodings for the Lx cache request arbiter.
// Message values match the cache controller's message include.
package lxcache_arb_pkg;

  localparam int MSG_W = 4;
  typedef logic [MSG_W-1:0] msg_t;

  localparam msg_t NO_REQ     = 4'd0;
  localparam msg_t WB_REQ     = 4'd1;
  localparam msg_t R_REQ      = 4'd2;
  localparam msg_t RFO_BCST   = 4'd3;
  localparam msg_t REQ_FLUSH  = 4'd4;
  localparam msg_t FLUSH      = 4'd5;
  localparam msg_t FLUSH_S    = 4'd6;
  localparam msg_t WS_BCST    = 4'd7;
  localparam msg_t C_WB       = 4'd8;
  localparam msg_t C_FLUSH    = 4'd9;
  localparam msg_t EN_ACCESS  = 4'd10;
  localparam msg_t MEM_RESP   = 4'd11;
  localparam msg_t MEM_RESP_S = 4'd12;
  localparam msg_t MEM_C_RESP = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RELEASE
  } arb_state_t;

  function automatic logic is_completion(input msg_t m);
    return (m == MEM_RESP) || (m == MEM_RESP_S) || (m == MEM_C_RESP);
  endfunction

endpackage

// File: rtl/lxcache_req_arbiter_picker.sv
// Round-robin picker: first eligible port strictly after rr_ptr, wrapping.
// Purely combinational; N must be a power of two so the index wraps for free.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  logic [IW-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = rr_ptr + IW'(k);
      if (!valid && eligible[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lxcache_req_arbiter.sv
// Shares the Lx cache controller's single request port among NUM_PORTS L1
// requesters, round-robin, and fans REQ_FLUSH callbacks out to all of them.
module lxcache_req_arbiter
  import lxcache_arb_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int ADDRESS_BITS = 32,
  parameter int CACHE_WIDTH  = 32,
  parameter int MSG_BITS     = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_PORTS*MSG_BITS-1:0]     req_msg,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0] req_address,
  input  logic [NUM_PORTS*CACHE_WIDTH-1:0]  req_data,
  output logic [NUM_PORTS*MSG_BITS-1:0]     resp_msg,
  output logic [ADDRESS_BITS-1:0]           resp_address,
  output logic [CACHE_WIDTH-1:0]            resp_data,
  output logic [NUM_PORTS-1:0]              grant,
  output logic [MSG_BITS-1:0]               ctrl_msg_in,
  output logic [ADDRESS_BITS-1:0]           ctrl_address,
  output logic [CACHE_WIDTH-1:0]            ctrl_data_in,
  output logic                              ctrl_pending_requests,
  input  logic [MSG_BITS-1:0]               ctrl_msg_out,
  input  logic [ADDRESS_BITS-1:0]           ctrl_out_address,
  input  logic [CACHE_WIDTH-1:0]            ctrl_data_out
);

  localparam int PW = $clog2(NUM_PORTS);

  arb_state_t state, state_next;

  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           owner;
  logic                    flush_mode;
  logic [ADDRESS_BITS-1:0] flush_addr;

  logic [MSG_BITS-1:0]     port_msg  [NUM_PORTS];
  logic [ADDRESS_BITS-1:0] port_addr [NUM_PORTS];
  logic [CACHE_WIDTH-1:0]  port_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]    present;
  logic [NUM_PORTS-1:0]    eligible;
  logic [NUM_PORTS-1:0]    pick_onehot;
  logic                    pick_valid;
  logic [PW-1:0]           pick_idx;

  logic completion_hit, flush_seen;
  logic do_grant, do_complete, do_flush, do_release;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign port_msg[i]  = req_msg[i*MSG_BITS +: MSG_BITS];
    assign port_addr[i] = req_address[i*ADDRESS_BITS +: ADDRESS_BITS];
    assign port_data[i] = req_data[i*CACHE_WIDTH +: CACHE_WIDTH];
    assign present[i]   = (port_msg[i] != NO_REQ);
    // While a flush is open only traffic that closes it may reach the controller.
    assign eligible[i]  = flush_mode
                        ? (((port_msg[i] == C_FLUSH) || (port_msg[i] == EN_ACCESS))
                           && (port_addr[i] == flush_addr))
                        : present[i];
  end

  assign ctrl_pending_requests = |(present & ~grant);

  rr_priority_picker #(.N(NUM_PORTS), .IW(PW)) u_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .winner   (pick_onehot),
    .valid    (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_onehot[i]) pick_idx = PW'(i);
    end
  end

  // ctrl_address holds the owner's latched address for the whole of ISSUE.
  assign completion_hit = is_completion(ctrl_msg_out) && (ctrl_out_address == ctrl_address);
  assign flush_seen     = (ctrl_msg_out == REQ_FLUSH);

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    do_grant    = 1'b0;
    do_complete = 1'b0;
    do_flush    = 1'b0;
    do_release  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (flush_seen) begin
          do_flush = 1'b1;
        end else if (pick_valid) begin
          do_grant   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (completion_hit) begin
          do_complete = 1'b1;
          state_next  = ST_RELEASE;
        end else if (flush_seen) begin
          do_flush   = 1'b1;
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (port_msg[owner] == NO_REQ) begin
          do_release = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr       <= PW'(NUM_PORTS - 1);
      owner        <= '0;
      flush_mode   <= 1'b0;
      flush_addr   <= '0;
      grant        <= '0;
      ctrl_msg_in  <= NO_REQ;
      ctrl_address <= '0;
      ctrl_data_in <= '0;
      resp_msg     <= {NUM_PORTS{NO_REQ}};
      resp_address <= '0;
      resp_data    <= '0;
    end else begin
      resp_msg <= {NUM_PORTS{NO_REQ}};
      if (do_grant) begin
        grant        <= pick_onehot;
        owner        <= pick_idx;
        ctrl_msg_in  <= port_msg[pick_idx];
        ctrl_address <= port_addr[pick_idx];
        ctrl_data_in <= port_data[pick_idx];
      end
      if (do_complete) begin
        resp_msg[owner*MSG_BITS +: MSG_BITS] <= ctrl_msg_out;
        resp_address <= ctrl_out_address;
        resp_data    <= ctrl_data_out;
        ctrl_msg_in  <= NO_REQ;
        rr_ptr       <= owner;
        if (ctrl_msg_in == EN_ACCESS) flush_mode <= 1'b0;
      end
      if (do_flush) begin
        flush_mode   <= 1'b1;
        flush_addr   <= ctrl_out_address;
        resp_msg     <= {NUM_PORTS{REQ_FLUSH}};
        resp_address <= ctrl_out_address;
        resp_data    <= ctrl_data_out;
        ctrl_msg_in  <= NO_REQ;
        if (state == ST_ISSUE) rr_ptr <= owner;
      end
      if (do_release) grant <= '0;
    end
  end

endmodule

// File: tb/tb_lxcache_req_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level round-robin/flush reference model.
module tb_lxcache_req_arbiter;
  import lxcache_arb_pkg::*;

  localparam int NP = 4;
  localparam int AB = 32;
  localparam int CW = 32;
  localparam int MB = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NP*MB-1:0]  req_msg = '0;
  logic [NP*AB-1:0]  req_address = '0;
  logic [NP*CW-1:0]  req_data = '0;
  logic [NP*MB-1:0]  resp_msg;
  logic [AB-1:0]     resp_address;
  logic [CW-1:0]     resp_data;
  logic [NP-1:0]     grant;
  logic [MB-1:0]     ctrl_msg_in;
  logic [AB-1:0]     ctrl_address;
  logic [CW-1:0]     ctrl_data_in;
  logic              ctrl_pending_requests;
  logic [MB-1:0]     ctrl_msg_out = NO_REQ;
  logic [AB-1:0]     ctrl_out_address = '0;
  logic [CW-1:0]     ctrl_data_out = '0;

  lxcache_req_arbiter #(
    .NUM_PORTS(NP), .ADDRESS_BITS(AB), .CACHE_WIDTH(CW), .MSG_BITS(MB)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .req_msg               (req_msg),
    .req_address           (req_address),
    .req_data              (req_data),
    .resp_msg              (resp_msg),
    .resp_address          (resp_address),
    .resp_data             (resp_data),
    .grant                 (grant),
    .ctrl_msg_in           (ctrl_msg_in),
    .ctrl_address          (ctrl_address),
    .ctrl_data_in          (ctrl_data_in),
    .ctrl_pending_requests (ctrl_pending_requests),
    .ctrl_msg_out          (ctrl_msg_out),
    .ctrl_out_address      (ctrl_out_address),
    .ctrl_data_out         (ctrl_data_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: last served port and open-flush bookkeeping.
  int          rr_last = NP - 1;
  bit          flush_on = 1'b0;
  logic [AB-1:0] flush_a = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MB-1:0] msg_of(input int i);
    return req_msg[i*MB +: MB];
  endfunction

  function automatic logic [AB-1:0] addr_of(input int i);
    return req_address[i*AB +: AB];
  endfunction

  function automatic logic [CW-1:0] data_of(input int i);
    return req_data[i*CW +: CW];
  endfunction

  task automatic set_req(input int i, input logic [MB-1:0] m, input logic [AB-1:0] a,
                         input logic [CW-1:0] d);
    req_msg[i*MB +: MB]     = m;
    req_address[i*AB +: AB] = a;
    req_data[i*CW +: CW]    = d;
  endtask

  task automatic drop(input int i);
    set_req(i, NO_REQ, '0, '0);
  endtask

  function automatic bit elig(input int i);
    logic [MB-1:0] m;
    m = msg_of(i);
    if (m == NO_REQ) return 1'b0;
    if (!flush_on) return 1'b1;
    return ((m == C_FLUSH) || (m == EN_ACCESS)) && (addr_of(i) == flush_a);
  endfunction

  function automatic int expect_winner();
    for (int k = 1; k <= NP; k++) begin
      if (elig((rr_last + k) % NP)) return (rr_last + k) % NP;
    end
    return -1;
  endfunction

  function automatic logic others_waiting(input int w);
    logic any;
    any = 1'b0;
    for (int i = 0; i < NP; i++) if (i != w && msg_of(i) != NO_REQ) any = 1'b1;
    return any;
  endfunction

  function automatic logic [MB-1:0] rand_req_msg();
    case ($urandom_range(2))
      0:       return R_REQ;
      1:       return WB_REQ;
      default: return EN_ACCESS;
    endcase
  endfunction

  function automatic logic [MB-1:0] rand_resp_msg();
    case ($urandom_range(2))
      0:       return MEM_RESP;
      1:       return MEM_RESP_S;
      default: return MEM_C_RESP;
    endcase
  endfunction

  task automatic ctrl_quiet();
    ctrl_msg_out     = NO_REQ;
    ctrl_out_address = '0;
    ctrl_data_out    = '0;
  endtask

  // Waits (bounded) for a grant, then checks owner and forwarded request.
  task automatic grant_phase(input int w, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (grant == '0 && n < 10);
    if (grant == '0) check("grant_timeout", 64'd0, 64'd1);
    check("grant", grant, 64'(NP'(1) << w));
    check("ctrl_msg_in", ctrl_msg_in, msg_of(w));
    check("ctrl_address", ctrl_address, addr_of(w));
    check("ctrl_data_in", ctrl_data_in, data_of(w));
    check("pending", ctrl_pending_requests, others_waiting(w));
  endtask

  // Controller answers the owner; optionally first sends a stray completion.
  task automatic finish_phase(input int w, input logic [MB-1:0] rmsg,
                              input logic [CW-1:0] rdata, input bit mismatch);
    logic [NP*MB-1:0] exp_resp;
    if (mismatch) begin
      ctrl_msg_out     = MEM_RESP;
      ctrl_out_address = ~addr_of(w);
      ctrl_data_out    = $urandom;
      @(negedge clock);
      check("stray_resp", resp_msg, {NP{NO_REQ}});
      check("stray_grant", grant, 64'(NP'(1) << w));
      check("stray_hold", ctrl_msg_in, msg_of(w));
      ctrl_quiet();
      @(negedge clock);
    end
    ctrl_msg_out     = rmsg;
    ctrl_out_address = addr_of(w);
    ctrl_data_out    = rdata;
    @(negedge clock);
    exp_resp = {NP{NO_REQ}};
    exp_resp[w*MB +: MB] = rmsg;
    check("resp_msg", resp_msg, exp_resp);
    check("resp_address", resp_address, addr_of(w));
    check("resp_data", resp_data, rdata);
    check("ctrl_idle_after_resp", ctrl_msg_in, NO_REQ);
    check("pending_in_release", ctrl_pending_requests, others_waiting(w));
    if (msg_of(w) == EN_ACCESS) flush_on = 1'b0;
    rr_last = w;
    ctrl_quiet();
    drop(w);
    @(negedge clock);
    check("resp_one_cycle", resp_msg, {NP{NO_REQ}});
    check("grant_released", grant, 64'd0);
  endtask

  task automatic serve(input int w, input logic [MB-1:0] rmsg, input logic [CW-1:0] rdata,
                       input bit mismatch);
    int n;
    grant_phase(w, n);
    finish_phase(w, rmsg, rdata, mismatch);
  endtask

  // A REQ_FLUSH lands at the next edge; check the broadcast it produces.
  task automatic flush_broadcast(input logic [AB-1:0] a);
    ctrl_msg_out     = REQ_FLUSH;
    ctrl_out_address = a;
    ctrl_data_out    = '0;
    @(negedge clock);
    check("flush_bcast_msg", resp_msg, {NP{REQ_FLUSH}});
    check("flush_bcast_addr", resp_address, a);
    check("flush_ctrl_idle", ctrl_msg_in, NO_REQ);
    flush_on = 1'b1;
    flush_a  = a;
    ctrl_quiet();
  endtask

  task automatic expect_blocked(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      check("blocked_grant", grant, 64'd0);
      check("blocked_pending", ctrl_pending_requests, 1'b1);
    end
  endtask

  initial begin
    int n, w;

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst_grant", grant, 64'd0);
    check("rst_ctrl_msg", ctrl_msg_in, NO_REQ);
    check("rst_ctrl_addr", ctrl_address, 64'd0);
    check("rst_resp_msg", resp_msg, {NP{NO_REQ}});
    check("rst_resp_addr", resp_address, 64'd0);
    check("rst_pending", ctrl_pending_requests, 1'b0);
    reset = 1'b1;

    // Single read, first grant one cycle after the request.
    set_req(0, R_REQ, 32'h1111_1144, '0);
    grant_phase(0, n);
    check("read_latency", n, 64'd1);
    finish_phase(0, MEM_RESP_S, 32'h1122_3344, 1'b0);

    // Fairness: 1, 2, 3 together, then 0 ahead of 2 after wrap.
    set_req(1, R_REQ, 32'h0000_1000, 32'h1);
    set_req(2, R_REQ, 32'h0000_2000, 32'h2);
    set_req(3, R_REQ, 32'h0000_3000, 32'h3);
    serve(1, MEM_RESP, 32'hA1, 1'b0);
    serve(2, MEM_RESP, 32'hA2, 1'b0);
    grant_phase(3, n);
    set_req(0, R_REQ, 32'h0000_0040, 32'h4);
    set_req(2, WB_REQ, 32'h0000_2040, 32'h5);
    finish_phase(3, MEM_RESP, 32'hA3, 1'b0);
    serve(0, MEM_RESP, 32'hA4, 1'b0);
    serve(2, MEM_RESP, 32'hA5, 1'b0);

    // Completion to the wrong address is ignored.
    set_req(1, R_REQ, 32'h1111_1148, '0);
    serve(1, MEM_RESP, 32'h5555_0001, 1'b1);

    // Controller flushes the owner's transaction.
    set_req(2, R_REQ, 32'h1122_3388, '0);
    grant_phase(2, n);
    flush_broadcast(32'h4444_4488);
    rr_last = 2;
    drop(2);
    @(negedge clock);
    check("flush_grant_release", grant, 64'd0);
    check("flush_resp_one_cycle", resp_msg, {NP{NO_REQ}});
    set_req(0, R_REQ, 32'h0000_0100, '0);
    set_req(2, R_REQ, 32'h1122_3388, '0);
    expect_blocked(3);
    set_req(3, C_FLUSH, 32'h4444_4488, 32'h0102_0304);
    serve(3, MEM_C_RESP, 32'h0, 1'b0);
    expect_blocked(2);
    set_req(1, EN_ACCESS, 32'h4444_4488, '0);
    serve(1, MEM_RESP, 32'h77, 1'b0);
    serve(2, MEM_RESP_S, 32'h88, 1'b0);
    serve(0, MEM_RESP, 32'h99, 1'b0);

    // Memory-side flush in IDLE beats a simultaneous request.
    set_req(0, R_REQ, 32'h0000_0200, '0);
    flush_broadcast(32'h3333_33CC);
    check("flush_beats_grant", grant, 64'd0);
    set_req(1, EN_ACCESS, 32'h1234_5678, '0);
    set_req(2, R_REQ, 32'h0000_0300, '0);
    set_req(3, EN_ACCESS, 32'h3333_33CC, '0);
    w = expect_winner();
    check("model_flush_pick", w, 64'd3);
    serve(3, MEM_RESP, 32'hCC, 1'b0);
    serve(0, MEM_RESP, 32'hD0, 1'b0);
    serve(1, MEM_RESP, 32'hD1, 1'b0);
    serve(2, MEM_RESP, 32'hD2, 1'b0);

    // Reset during ISSUE drops the grant and the open flush.
    flush_broadcast(32'hDEAD_0000);
    set_req(3, EN_ACCESS, 32'hDEAD_0000, '0);
    set_req(0, R_REQ, 32'h0000_0400, '0);
    grant_phase(3, n);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_grant", grant, 64'd0);
    check("midrst_ctrl_msg", ctrl_msg_in, NO_REQ);
    check("midrst_ctrl_addr", ctrl_address, 64'd0);
    check("midrst_resp", resp_msg, {NP{NO_REQ}});
    reset    = 1'b1;
    rr_last  = NP - 1;
    flush_on = 1'b0;
    serve(0, MEM_RESP, 32'hE0, 1'b0);
    serve(3, MEM_RESP, 32'hE3, 1'b0);

    // Randomized traffic in normal mode.
    for (int t = 0; t < 40; t++) begin
      if (req_msg == '0) begin
        w = $urandom_range(NP - 1);
        set_req(w, rand_req_msg(), $urandom, $urandom);
      end
      w = expect_winner();
      grant_phase(w, n);
      for (int i = 0; i < NP; i++) begin
        if (i != w && msg_of(i) == NO_REQ && $urandom_range(1) == 1)
          set_req(i, rand_req_msg(), $urandom, $urandom);
      end
      finish_phase(w, rand_resp_msg(), $urandom, $urandom_range(3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
